// File: rtl/alu4_sync.sv
// Registered WIDTH-bit ALU: eight arithmetic/logic/shift ops with carry and zero
// flags, one cycle of latency, valid strobe in and out.
module alu4_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             Carry_out,
    output logic             zero,
    output logic             out_valid
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q;
    logic             vld_q;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    // Both arithmetic paths use one extra bit so the MSB carries carry/borrow.
    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign diff_w = {1'b0, A} - {1'b0, B};

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        case (opcode)
            OP_ADD: {carry_d, result_d} = sum_w;
            OP_SUB: {carry_d, result_d} = diff_w;
            OP_AND: result_d = A & B;
            OP_OR:  result_d = A | B;
            OP_XOR: result_d = A ^ B;
            OP_NOT: result_d = ~A;
            OP_SHL: begin
                result_d = {A[WIDTH-2:0], 1'b0};
                carry_d  = A[WIDTH-1];
            end
            OP_SHR: begin
                result_d = {1'b0, A[WIDTH-1:1]};
                carry_d  = A[0];
            end
            default: begin
                result_d = '0;
                carry_d  = 1'b0;
            end
        endcase
    end

    // Output stage: flags are taken from the new result, never the held one.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                zero_q   <= (result_d == '0);
            end
        end
    end

    assign result    = result_q;
    assign Carry_out = carry_q;
    assign zero      = zero_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_alu4_sync.sv
// Bench for alu4_sync: directed vector table, hold/latency/reset sequences and a
// random sweep against an integer-arithmetic reference model.
module tb_alu4_sync;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A, B;
    logic [2:0]   opcode;
    logic [W-1:0] result;
    logic         Carry_out;
    logic         zero;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    alu4_sync #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .result(result), .Carry_out(Carry_out), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } vec_t;

    vec_t vecs[12];

    // Reference model: plain integer arithmetic on unsigned values.
    function automatic void model(input int a, input int b, input int op,
                                  output logic [W-1:0] r, output logic c);
        int v;
        v = 0;
        c = 1'b0;
        case (op)
            0: begin v = a + b; c = (v >= M); v = v % M; end
            1: begin c = (a < b); v = (a - b + M) % M; end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = (M - 1) - a;
            6: begin c = (a >= M / 2); v = (a * 2) % M; end
            default: begin c = (a % 2) == 1; v = a / 2; end
        endcase
        r = v[W-1:0];
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
        in_valid = v;
        A        = a;
        B        = b;
        opcode   = op;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r, input logic c,
                           input logic z, input logic v);
        chk({tag, ".result"}, int'(result), int'(r));
        chk({tag, ".carry"}, int'(Carry_out), int'(c));
        chk({tag, ".zero"}, int'(zero), int'(z));
        chk({tag, ".valid"}, int'(out_valid), int'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] er, hr;
        logic         ec, hc, hz;
        vec_t         q[$];

        vecs[0]  = '{4'b0111, 4'b1011, 3'b000, 4'b0010, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 4'b1110, 3'b001, 4'b0001, 1'b0, 1'b0};
        vecs[2]  = '{4'b0011, 4'b0101, 3'b001, 4'b1110, 1'b1, 1'b0};
        vecs[3]  = '{4'b1010, 4'b1010, 3'b010, 4'b1010, 1'b0, 1'b0};
        vecs[4]  = '{4'b0101, 4'b1011, 3'b011, 4'b1111, 1'b0, 1'b0};
        vecs[5]  = '{4'b0111, 4'b1100, 3'b100, 4'b1011, 1'b0, 1'b0};
        vecs[6]  = '{4'b1010, 4'b1010, 3'b100, 4'b0000, 1'b0, 1'b1};
        vecs[7]  = '{4'b1111, 4'b0110, 3'b101, 4'b0000, 1'b0, 1'b1};
        vecs[8]  = '{4'b1001, 4'b0011, 3'b110, 4'b0010, 1'b1, 1'b0};
        vecs[9]  = '{4'b1001, 4'b1100, 3'b111, 4'b0100, 1'b1, 1'b0};
        vecs[10] = '{4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 3'b001, 4'b0000, 1'b0, 1'b1};

        rst = 1'b1;
        drive(1'b0, '0, '0, 3'b000);
        step();
        step();
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed table, back-to-back.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].z, 1'b1);
        end

        // Hold: idle cycles with moving operands must not disturb the outputs.
        drive(1'b1, 4'b0110, 4'b0101, 3'b000);
        step();
        chk_out("hold_op", 4'b1011, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, W'($urandom), W'($urandom), 3'($urandom));
            step();
            chk_out($sformatf("hold%0d", i), 4'b1011, 1'b0, 1'b0, 1'b0);
        end

        // Five back-to-back random ops, each one cycle after its inputs.
        for (int i = 0; i < 5; i++) begin
            vec_t t;
            t.a  = W'($urandom);
            t.b  = W'($urandom);
            t.op = 3'($urandom);
            model(int'(t.a), int'(t.b), int'(t.op), t.r, t.c);
            t.z  = (t.r == 0);
            q.push_back(t);
            drive(1'b1, t.a, t.b, t.op);
            step();
            t = q.pop_front();
            chk_out($sformatf("b2b%0d", i), t.r, t.c, t.z, 1'b1);
        end

        // Mid-stream reset with in_valid held high.
        drive(1'b1, 4'b1000, 4'b1001, 3'b000);
        step();
        chk_out("pre_rst", 4'b0001, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b1, 4'b0101, 4'b0011, 3'b011);
        step();
        chk_out("rst_c0", '0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("rst_c1", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 4'b1100, 4'b0000, 3'b111);
        step();
        chk_out("post_rst", 4'b0110, 1'b0, 1'b0, 1'b1);
        hr = 4'b0110; hc = 1'b0; hz = 1'b0;

        // Random sweep with sporadic idle cycles.
        for (int i = 0; i < 300; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            drive(v, W'($urandom), W'($urandom), 3'($urandom));
            if (v) begin
                model(int'(A), int'(B), int'(opcode), er, ec);
                hr = er;
                hc = ec;
                hz = (er == 0);
            end
            step();
            chk_out($sformatf("rnd%0d", i), hr, hc, hz, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
